// File: rtl/sram_2p_param.sv
// Parametrised 1R/1W SRAM model with lane write mask, RD_LAT-cycle registered read and collision modes.
// Latency: RD_LAT cycles from the issue edge to VLD1; no backpressure, so every accepted read completes.
module sram_2p_param #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 1296,
    parameter int AW       = 11,
    parameter int LANE     = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                    CE,
    input  logic                    RST,
    input  logic                    CSB1,
    input  logic                    OEB1,
    input  logic [AW-1:0]           A1,
    output logic [WIDTH-1:0]        O1,
    output logic                    VLD1,
    output logic                    ERR1,
    input  logic                    CSB2,
    input  logic                    WEB2,
    input  logic [WIDTH/LANE-1:0]   BWEB2,
    input  logic [AW-1:0]           A2,
    input  logic [WIDTH-1:0]        I2,
    output logic                    ERR2
);

    localparam int          NL      = WIDTH / LANE;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [WIDTH-1:0] bit_mask;
    logic             rd_acc, rd_inr;
    logic             wr_acc, wr_inr, wr_en;
    logic [WIDTH-1:0] wr_old, wr_word, rd_raw, rd_dat;

    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < NL; k++) begin
            bit_mask[k*LANE +: LANE] = {LANE{~BWEB2[k]}};
        end
        rd_acc  = !CSB1;
        rd_inr  = {1'b0, A1} < DEPTH_W;
        wr_acc  = !CSB2 && !WEB2;
        wr_inr  = {1'b0, A2} < DEPTH_W;
        wr_en   = wr_acc && wr_inr;
        wr_old  = wr_inr ? mem[A2] : '0;
        wr_word = (wr_old & ~bit_mask) | (I2 & bit_mask);
        rd_raw  = rd_inr ? mem[A1] : '0;
        rd_dat  = rd_raw;
        // Write-through merges only the lanes the concurrent write actually updates.
        if (RDW_MODE != 0 && wr_en && A1 == A2) begin
            rd_dat = (rd_raw & ~bit_mask) | (I2 & bit_mask);
        end
    end

    // Contents survive reset; the reset term only blocks writes sampled while RST is high.
    always_ff @(posedge CE or posedge RST) begin
        if (!RST) begin
            if (wr_en) begin
                mem[A2] <= wr_word;
            end
        end
    end

    logic             fin_vld, fin_err, fin_oe;
    logic [WIDTH-1:0] fin_dat;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             s1_vld_d, s1_vld_q, s1_err_d, s1_err_q, s1_oe_d, s1_oe_q;
            logic [WIDTH-1:0] s1_dat_d, s1_dat_q;

            always_comb begin
                s1_vld_d = rd_acc;
                s1_err_d = rd_acc && !rd_inr;
                s1_oe_d  = !OEB1;
                s1_dat_d = rd_dat;
            end

            always_ff @(posedge CE or posedge RST) begin
                if (RST) begin
                    s1_vld_q <= 1'b0;
                    s1_err_q <= 1'b0;
                    s1_oe_q  <= 1'b0;
                    s1_dat_q <= '0;
                end else begin
                    s1_vld_q <= s1_vld_d;
                    s1_err_q <= s1_err_d;
                    s1_oe_q  <= s1_oe_d;
                    s1_dat_q <= s1_dat_d;
                end
            end

            assign fin_vld = s1_vld_q;
            assign fin_err = s1_err_q;
            assign fin_oe  = s1_oe_q;
            assign fin_dat = s1_dat_q;
        end else begin : g_lat1
            assign fin_vld = rd_acc;
            assign fin_err = !rd_inr;
            assign fin_oe  = !OEB1;
            assign fin_dat = rd_dat;
        end
    endgenerate

    logic [WIDTH-1:0] o1_d, o1_q;
    logic             vld1_d, vld1_q, err1_d, err1_q, err2_d, err2_q;

    always_comb begin
        o1_d   = o1_q;
        vld1_d = fin_vld;
        err1_d = fin_vld && fin_err;
        err2_d = err2_q;
        if (fin_vld && fin_oe) begin
            o1_d = fin_dat;
        end
        if (wr_acc) begin
            err2_d = !wr_inr;
        end
    end

    always_ff @(posedge CE or posedge RST) begin
        if (RST) begin
            o1_q   <= '0;
            vld1_q <= 1'b0;
            err1_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            o1_q   <= o1_d;
            vld1_q <= vld1_d;
            err1_q <= err1_d;
            err2_q <= err2_d;
        end
    end

    assign O1   = o1_q;
    assign VLD1 = vld1_q;
    assign ERR1 = err1_q;
    assign ERR2 = err2_q;

endmodule

// File: tb/tb_sram_2p_param.sv
// Directed bench: one RD_LAT=1/old-data instance (a) and one RD_LAT=2/write-through instance (b) on shared inputs.
module tb_sram_2p_param;

    localparam logic [127:0] PA5  = {16{8'hA5}};
    localparam logic [127:0] P3C  = {16{8'h3C}};
    localparam logic [127:0] P11  = {16{8'h11}};
    localparam logic [127:0] P22  = {16{8'h22}};
    localparam logic [127:0] PAB  = {16{8'hAB}};
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] M7   = {{15{8'hFF}}, 8'h00};

    logic         clk, rst, csb1, oeb1, csb2, web2;
    logic [10:0]  a1, a2;
    logic [15:0]  bweb2;
    logic [127:0] i2;
    logic [127:0] o1_a, o1_b;
    logic         vld1_a, err1_a, err2_a, vld1_b, err1_b, err2_b;

    int n_cmp = 0;
    int n_err = 0;

    sram_2p_param #(.WIDTH(128), .DEPTH(1296), .AW(11), .LANE(8), .RD_LAT(1), .RDW_MODE(0)) dut_a (
        .CE(clk), .RST(rst), .CSB1(csb1), .OEB1(oeb1), .A1(a1), .O1(o1_a), .VLD1(vld1_a),
        .ERR1(err1_a), .CSB2(csb2), .WEB2(web2), .BWEB2(bweb2), .A2(a2), .I2(i2), .ERR2(err2_a));

    sram_2p_param #(.WIDTH(128), .DEPTH(1296), .AW(11), .LANE(8), .RD_LAT(2), .RDW_MODE(1)) dut_b (
        .CE(clk), .RST(rst), .CSB1(csb1), .OEB1(oeb1), .A1(a1), .O1(o1_b), .VLD1(vld1_b),
        .ERR1(err1_b), .CSB2(csb2), .WEB2(web2), .BWEB2(bweb2), .A2(a2), .I2(i2), .ERR2(err2_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [10:0] addr, input logic [127:0] dat, input logic [15:0] mask);
        csb2 = 1'b0; web2 = 1'b0; a2 = addr; i2 = dat; bweb2 = mask;
        tick();
        csb2 = 1'b1; web2 = 1'b1;
    endtask

    task automatic rd(input logic [10:0] addr, input logic oeb);
        csb1 = 1'b0; a1 = addr; oeb1 = oeb;
        tick();
        csb1 = 1'b1; oeb1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; csb1 = 1'b1; oeb1 = 1'b0; a1 = '0;
        csb2 = 1'b1; web2 = 1'b1; bweb2 = '0; a2 = '0; i2 = '0;
        tick(); tick();
        chkw("rst_o1_a", o1_a, '0);
        chk1("rst_vld_a", vld1_a, 1'b0);
        chk1("rst_err1_a", err1_a, 1'b0);
        chk1("rst_err2_a", err2_a, 1'b0);
        chkw("rst_o1_b", o1_b, '0);
        chk1("rst_vld_b", vld1_b, 1'b0);
        rst = 1'b0;
        tick();

        // basic write/read at both latencies
        wr(11'd0, PA5, 16'h0000);
        wr(11'd1295, P3C, 16'h0000);
        chk1("t1_err2_a", err2_a, 1'b0);
        rd(11'd0, 1'b0);
        chk1("t1_a0_vld", vld1_a, 1'b1);
        chkw("t1_a0_dat", o1_a, PA5);
        chk1("t1_a0_err", err1_a, 1'b0);
        chk1("t1_b0_early_vld", vld1_b, 1'b0);
        chkw("t1_b0_early_dat", o1_b, '0);
        tick();
        chk1("t1_a0_idle_vld", vld1_a, 1'b0);
        chkw("t1_a0_hold", o1_a, PA5);
        chk1("t1_b0_vld", vld1_b, 1'b1);
        chkw("t1_b0_dat", o1_b, PA5);
        chk1("t1_b0_err", err1_b, 1'b0);
        rd(11'd1295, 1'b0);
        chk1("t1_a1295_vld", vld1_a, 1'b1);
        chkw("t1_a1295_dat", o1_a, P3C);
        tick();
        chk1("t1_b1295_vld", vld1_b, 1'b1);
        chkw("t1_b1295_dat", o1_b, P3C);

        // lane mask: only lane 0 cleared
        wr(11'd7, ONES, 16'h0000);
        wr(11'd7, '0, 16'hFFFE);
        rd(11'd7, 1'b0);
        chkw("t2_a_mask", o1_a, M7);
        tick();
        chkw("t2_b_mask", o1_b, M7);

        // same-address read/write collision
        wr(11'd5, P11, 16'h0000);
        csb1 = 1'b0; a1 = 11'd5; csb2 = 1'b0; web2 = 1'b0; a2 = 11'd5; i2 = P22; bweb2 = 16'h0000;
        tick();
        csb1 = 1'b1; csb2 = 1'b1; web2 = 1'b1;
        chk1("t3_a_vld", vld1_a, 1'b1);
        chkw("t3_a_olddata", o1_a, P11);
        tick();
        chk1("t3_b_vld", vld1_b, 1'b1);
        chkw("t3_b_writethru", o1_b, P22);

        // out-of-range write and read
        wr(11'd1300, ONES, 16'h0000);
        chk1("t4_err2_set_a", err2_a, 1'b1);
        chk1("t4_err2_set_b", err2_b, 1'b1);
        rd(11'd1300, 1'b0);
        chk1("t4_a_vld", vld1_a, 1'b1);
        chk1("t4_a_err1", err1_a, 1'b1);
        chkw("t4_a_dat", o1_a, '0);
        chk1("t4_b_err1_early", err1_b, 1'b0);
        chk1("t4_err2_hold_a", err2_a, 1'b1);
        tick();
        chk1("t4_a_err1_clr", err1_a, 1'b0);
        chk1("t4_b_vld", vld1_b, 1'b1);
        chk1("t4_b_err1", err1_b, 1'b1);
        chkw("t4_b_dat", o1_b, '0);
        wr(11'd3, PAB, 16'h0000);
        chk1("t4_err2_clr_a", err2_a, 1'b0);
        chk1("t4_err2_clr_b", err2_b, 1'b0);

        // reset during back-to-back reads; write under reset is dropped
        csb1 = 1'b0; a1 = 11'd0;
        tick();
        a1 = 11'd1295;
        tick();
        chk1("t5_b_vld_pre", vld1_b, 1'b1);
        chkw("t5_b_dat_pre", o1_b, PA5);
        rst = 1'b1; a1 = 11'd7;
        csb2 = 1'b0; web2 = 1'b0; a2 = 11'd7; i2 = '0; bweb2 = 16'h0000;
        #1;
        chkw("t5_a_o1_rst", o1_a, '0);
        chk1("t5_a_vld_rst", vld1_a, 1'b0);
        chkw("t5_b_o1_rst", o1_b, '0);
        chk1("t5_b_vld_rst", vld1_b, 1'b0);
        tick();
        a1 = 11'd5;
        tick();
        rst = 1'b0; csb1 = 1'b1; csb2 = 1'b1; web2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t5_a_no_vld", vld1_a, 1'b0);
            chk1("t5_b_no_vld", vld1_b, 1'b0);
        end
        rd(11'd7, 1'b0);
        chkw("t5_a_nowrite", o1_a, M7);
        tick();
        chkw("t5_b_nowrite", o1_b, M7);

        // output enable held off: valid pulses, data holds
        wr(11'd9, PAB, 16'h0000);
        rd(11'd9, 1'b0);
        chkw("t6_a_pre", o1_a, PAB);
        tick();
        chkw("t6_b_pre", o1_b, PAB);
        rd(11'd0, 1'b1);
        chk1("t6_a_vld", vld1_a, 1'b1);
        chkw("t6_a_hold", o1_a, PAB);
        chk1("t6_a_err1", err1_a, 1'b0);
        tick();
        chk1("t6_b_vld", vld1_b, 1'b1);
        chkw("t6_b_hold", o1_b, PAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
